// File: rtl/calculator_pkg.sv
// Shared widths and FSM state encoding for the calculator controller.
package calculator_pkg;

  localparam int ADDR_W        = 10;
  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ADD   = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } calc_state_e;

endpackage

// File: rtl/calc_controller_if.sv
// Control/memory/ALU signal bundle for calc_controller.
// abort_i exists only when CALC_ABORT_EN is defined.
interface calc_controller_if;
  import calculator_pkg::*;

`ifdef CALC_ABORT_EN
  logic                     abort_i;
`endif
  logic                     start_i;
  logic [ADDR_W-1:0]        read_start_addr_i;
  logic [ADDR_W-1:0]        read_end_addr_i;
  logic [ADDR_W-1:0]        write_start_addr_i;
  logic                     mem_rd_en_o;
  logic [ADDR_W-1:0]        mem_rd_addr_o;
  logic [MEM_WORD_SIZE-1:0] mem_rd_data_i;
  logic [DATA_W-1:0]        op_a_o;
  logic [DATA_W-1:0]        op_b_o;
  logic                     loc_sel_o;
  logic                     buffer_write_o;
  logic                     mem_wr_en_o;
  logic [ADDR_W-1:0]        mem_wr_addr_o;
  logic                     busy_o;
  logic                     done_o;

  modport master (
`ifdef CALC_ABORT_EN
    input  abort_i,
`endif
    input  start_i, read_start_addr_i, read_end_addr_i, write_start_addr_i,
    input  mem_rd_data_i,
    output mem_rd_en_o, mem_rd_addr_o, op_a_o, op_b_o, loc_sel_o,
    output buffer_write_o, mem_wr_en_o, mem_wr_addr_o, busy_o, done_o
  );

  modport slave (
`ifdef CALC_ABORT_EN
    output abort_i,
`endif
    output start_i, read_start_addr_i, read_end_addr_i, write_start_addr_i,
    output mem_rd_data_i,
    input  mem_rd_en_o, mem_rd_addr_o, op_a_o, op_b_o, loc_sel_o,
    input  buffer_write_o, mem_wr_en_o, mem_wr_addr_o, busy_o, done_o
  );

endinterface

// File: rtl/calc_controller.sv
// Sequencer: reads word pairs, feeds the ALU, writes packed results back.
// Optional CALC_ABORT_EN adds abort_i to cancel a run without done_o.
module calc_controller
  import calculator_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  calc_controller_if.master bus
);

  localparam logic [2:0] IDLE  = 3'(ST_IDLE);
  localparam logic [2:0] READ  = 3'(ST_READ);
  localparam logic [2:0] WAIT  = 3'(ST_WAIT);
  localparam logic [2:0] ADD   = 3'(ST_ADD);
  localparam logic [2:0] WRITE = 3'(ST_WRITE);
  localparam logic [2:0] DONE  = 3'(ST_DONE);

  logic [2:0]               state;
  logic [2:0]               state_nxt;
  logic [ADDR_W-1:0]        rd_ptr;
  logic [ADDR_W-1:0]        rd_end;
  logic [ADDR_W-1:0]        wr_ptr;
  logic                     lane;
  logic [MEM_WORD_SIZE-1:0] operand;
  logic                     abort;
  logic                     last_rd;

`ifdef CALC_ABORT_EN
  assign abort = bus.abort_i && (state != IDLE);
`else
  assign abort = 1'b0;
`endif

  // End-of-range test is taken before any increment, so read_end at the top
  // of the address space never wraps the read pointer.
  assign last_rd = (rd_ptr == rd_end);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start_i)
               state_nxt = (bus.read_end_addr_i < bus.read_start_addr_i) ? DONE : READ;
      READ:  state_nxt = WAIT;
      WAIT:  state_nxt = ADD;
      ADD:   state_nxt = (lane || last_rd) ? WRITE : READ;
      WRITE: state_nxt = last_rd ? DONE : READ;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      rd_end  <= '0;
      wr_ptr  <= '0;
      lane    <= 1'b0;
      operand <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.start_i) begin
          rd_ptr <= bus.read_start_addr_i;
          rd_end <= bus.read_end_addr_i;
          wr_ptr <= bus.write_start_addr_i;
          lane   <= 1'b0;
        end
        WAIT: operand <= bus.mem_rd_data_i;
        ADD: if (!(lane || last_rd)) begin
          lane   <= 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        WRITE: begin
          wr_ptr <= wr_ptr + 1'b1;
          lane   <= 1'b0;
          if (!last_rd) rd_ptr <= rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // An odd read count leaves the upper buffer half holding its previous value.
  always_comb begin
    bus.mem_rd_en_o    = 1'b0;
    bus.mem_rd_addr_o  = '0;
    bus.op_a_o         = '0;
    bus.op_b_o         = '0;
    bus.loc_sel_o      = 1'b0;
    bus.buffer_write_o = 1'b1;
    bus.mem_wr_en_o    = 1'b0;
    bus.mem_wr_addr_o  = '0;
    bus.busy_o         = (state != IDLE);
    bus.done_o         = (state == DONE) && !abort;
    case (state)
      READ: begin
        bus.mem_rd_en_o   = 1'b1;
        bus.mem_rd_addr_o = rd_ptr;
      end
      ADD: begin
        bus.op_a_o         = operand[MEM_WORD_SIZE-1 -: DATA_W];
        bus.op_b_o         = operand[DATA_W-1:0];
        bus.loc_sel_o      = lane;
        bus.buffer_write_o = 1'b0;
      end
      WRITE: begin
        bus.mem_wr_en_o   = !abort;
        bus.mem_wr_addr_o = wr_ptr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_calc_controller.sv
// Directed, table-driven bench for calc_controller with a synchronous memory model.
module tb_calc_controller;
  import calculator_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calc_controller_if bus();

  calc_controller dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [9:0] rs;
    logic [9:0] re;
    logic [9:0] ws;
    int         n_rd;
    int         n_wr;
    int         first_wr_cyc;
    int         done_cyc;
  } vec_t;

  logic [63:0] mem [0:1023];
  int          cyc = 0;
  int          start_cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  int          rd_addr_q[$];
  int          wr_addr_q[$];
  int          wr_cyc_q[$];
  logic [31:0] opa_q[$];
  logic [31:0] opb_q[$];
  logic        ls_q[$];
  int          done_n;
  int          done_rel;
  int          busy_n;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.mem_rd_en_o) bus.mem_rd_data_i <= mem[bus.mem_rd_addr_o];

  always @(negedge clk) begin
    if (bus.mem_rd_en_o) rd_addr_q.push_back(int'(bus.mem_rd_addr_o));
    if (bus.mem_wr_en_o) begin
      wr_addr_q.push_back(int'(bus.mem_wr_addr_o));
      wr_cyc_q.push_back(cyc - start_cyc);
    end
    if (!bus.buffer_write_o) begin
      opa_q.push_back(bus.op_a_o);
      opb_q.push_back(bus.op_b_o);
      ls_q.push_back(bus.loc_sel_o);
    end
    if (bus.done_o) begin
      done_n   = done_n + 1;
      done_rel = cyc - start_cyc;
    end
    if (bus.busy_o) busy_n = busy_n + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    rd_addr_q.delete(); wr_addr_q.delete(); wr_cyc_q.delete();
    opa_q.delete(); opb_q.delete(); ls_q.delete();
    done_n = 0; done_rel = -1; busy_n = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},   64'(bus.busy_o), 64'd0);
    check({tag, "_outs"},
          {56'd0, bus.mem_rd_en_o, bus.mem_wr_en_o, bus.buffer_write_o, bus.loc_sel_o, bus.done_o, 3'd0},
          {56'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0});
    check({tag, "_ops"}, {bus.op_a_o, bus.op_b_o}, 64'd0);
  endtask

  task automatic start_run(input logic [9:0] rs, input logic [9:0] re, input logic [9:0] ws,
                           input bit hold);
    clear_log();
    @(posedge clk); #1;
    bus.read_start_addr_i  = rs;
    bus.read_end_addr_i    = re;
    bus.write_start_addr_i = ws;
    bus.start_i            = 1'b1;
    start_cyc              = cyc;
    @(posedge clk); #1;
    if (!hold) bus.start_i = 1'b0;
    bus.read_start_addr_i  = 10'h155;
    bus.read_end_addr_i    = 10'h3AA;
    bus.write_start_addr_i = 10'h0F0;
  endtask

  task automatic run_vec(input vec_t v, input bit hold, input string tag);
    start_run(v.rs, v.re, v.ws, hold);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_n > 0) break;
    end
    bus.start_i = 1'b0;
    check({tag, "_done_seen"}, 64'(done_n > 0), 64'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    check({tag, "_rd_cnt"}, 64'(rd_addr_q.size()), 64'(v.n_rd));
    for (int k = 0; k < v.n_rd && k < rd_addr_q.size(); k++)
      check($sformatf("%s_rd_addr%0d", tag, k), 64'(rd_addr_q[k]), 64'((int'(v.rs) + k) % 1024));
    check({tag, "_wr_cnt"}, 64'(wr_addr_q.size()), 64'(v.n_wr));
    for (int k = 0; k < v.n_wr && k < wr_addr_q.size(); k++)
      check($sformatf("%s_wr_addr%0d", tag, k), 64'(wr_addr_q[k]), 64'((int'(v.ws) + k) % 1024));
    if (v.n_wr > 0 && wr_cyc_q.size() > 0)
      check({tag, "_wr_cyc"}, 64'(wr_cyc_q[0]), 64'(v.first_wr_cyc));
    check({tag, "_op_cnt"}, 64'(opa_q.size()), 64'(v.n_rd));
    for (int k = 0; k < v.n_rd && k < opa_q.size(); k++) begin
      check($sformatf("%s_opa%0d", tag, k), 64'(opa_q[k]), 64'(2 * (int'(v.rs) + k) + 1));
      check($sformatf("%s_opb%0d", tag, k), 64'(opb_q[k]), 64'(2 * (int'(v.rs) + k) + 2));
      check($sformatf("%s_lsel%0d", tag, k), 64'(ls_q[k]), 64'(k % 2));
    end
    check({tag, "_done_cnt"}, 64'(done_n), 64'd1);
    check({tag, "_done_cyc"}, 64'(done_rel), 64'(v.done_cyc));
    check({tag, "_busy_cyc"}, 64'(busy_n), 64'(v.done_cyc));
    check_idle(tag);
  endtask

  vec_t vecs[5];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {32'(2 * i + 1), 32'(2 * i + 2)};
`ifdef CALC_ABORT_EN
    bus.abort_i = 1'b0;
`endif
    bus.start_i = 1'b0;
    bus.read_start_addr_i  = '0;
    bus.read_end_addr_i    = '0;
    bus.write_start_addr_i = '0;
    bus.mem_rd_data_i      = '0;
    clear_log();

    //          rs      re      ws      rd wr 1stwr done
    vecs[0] = '{10'd0,    10'd1,    10'h008, 2, 1, 7,  8};
    vecs[1] = '{10'd4,    10'd6,    10'h010, 3, 2, 7,  12};
    vecs[2] = '{10'd5,    10'd2,    10'h003, 0, 0, 0,  1};
    vecs[3] = '{10'd1020, 10'd1023, 10'h3FF, 4, 2, 7,  15};
    vecs[4] = '{10'd9,    10'd9,    10'h020, 1, 1, 4,  5};

    #12;
    check_idle("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], 1'b0, $sformatf("v%0d", i));
      check_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Reset asserted while the controller sits in WAIT
    start_run(10'd0, 10'd1, 10'h008, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid_wr_cnt", 64'(wr_addr_q.size()), 64'd0);
    check("rst_mid_done_cnt", 64'(done_n), 64'd0);
    run_vec(vecs[0], 1'b0, "rerun");
    check_vec(vecs[0], "rerun");

    // start held high for the whole run still yields a single run
    run_vec(vecs[0], 1'b1, "hold");
    repeat (4) @(posedge clk);
    #1;
    check_vec(vecs[0], "hold");

`ifdef CALC_ABORT_EN
    start_run(10'd0, 10'd1, 10'h008, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    bus.abort_i = 1'b1;
    #1;
    check("abort_in_add", 64'(bus.buffer_write_o), 64'd0);
    @(posedge clk); #1;
    bus.abort_i = 1'b0;
    check_idle("abort_next");
    repeat (10) @(posedge clk);
    #1;
    check("abort_wr_cnt", 64'(wr_addr_q.size()), 64'd0);
    check("abort_done_cnt", 64'(done_n), 64'd0);

    start_run(10'd0, 10'd1, 10'h008, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    bus.abort_i = 1'b1;
    #1;
    check("abort_wr_suppr", 64'(bus.mem_wr_en_o), 64'd0);
    @(posedge clk); #1;
    bus.abort_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort2_wr_cnt", 64'(wr_addr_q.size()), 64'd0);
    check("abort2_done_cnt", 64'(done_n), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_controller.md
CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 Parameters (from calculator_pkg): ADDR_W, default 10, memory address width; DATA_W, default 32, ALU operand/result width; MEM_WORD_SIZE, default 64, memory word width.
REQ-002 clk_i  in  1  sole clock, all state updates on posedge.
REQ-003 rst_i  in  1  asynchronous, active-low reset.
REQ-004 start_i  in  1  begin a run; sampled only in IDLE.
REQ-005 read_start_addr_i / read_end_addr_i / write_start_addr_i  in  ADDR_W each  inclusive read range and first write address.
REQ-006 mem_rd_en_o  out  1;  mem_rd_addr_o  out  ADDR_W;  mem_rd_data_i  in  MEM_WORD_SIZE  synchronous read, data valid 1 cycle after mem_rd_en_o.
REQ-007 op_a_o / op_b_o  out  DATA_W  ALU operands: mem word [63:32] / [31:0].
REQ-008 loc_sel_o  out  1  result-buffer half select (0 = lower, 1 = upper).
REQ-009 buffer_write_o  out  1  result-buffer capture control: low = buffer captures ALU result this cycle, high = buffer holds.
REQ-010 mem_wr_en_o  out  1;  mem_wr_addr_o  out  ADDR_W  write of the 64-bit result-buffer output.
REQ-011 busy_o  out  1  high in every state except IDLE;  done_o  out  1  single-cycle run-complete pulse.

Function
REQ-012 FSM states IDLE, READ, WAIT, ADD, WRITE, DONE.
REQ-013 IDLE: start_i=1 latches addresses, rd_ptr=read_start, wr_ptr=write_start, lane=0; next READ, or DONE if read_end < read_start (no memory access).
REQ-014 READ: mem_rd_en_o=1, mem_rd_addr_o=rd_ptr; next WAIT.
REQ-015 WAIT: register mem_rd_data_i into operand register; next ADD.
REQ-016 ADD: op_a_o/op_b_o from operand register, buffer_write_o=0, loc_sel_o=lane; next WRITE if lane=1 or rd_ptr=read_end, else lane<=1, rd_ptr++, next READ.
REQ-017 WRITE: mem_wr_en_o=1, mem_wr_addr_o=wr_ptr; wr_ptr++, lane<=0; next DONE if rd_ptr=read_end, else rd_ptr++, next READ.
REQ-018 DONE: done_o=1 for exactly one cycle; next IDLE.
REQ-019 Latency: 7 cycles per full output word (two reads); N reads produce ceil(N/2) writes.
REQ-020 Odd read count: final word written with lane 1 unwritten; upper half carries the previous buffer value, documented, not cleared.
REQ-021 End-of-range compare precedes increment; read_end = 2^ADDR_W-1 never wraps. wr_ptr wraps modulo 2^ADDR_W.
REQ-022 start_i outside IDLE ignored; address inputs sampled only at start.
REQ-023 Outside active states: mem_rd_en_o=0, mem_wr_en_o=0, buffer_write_o=1, loc_sel_o=0, op outputs 0.

Reset
REQ-024 rst_i low immediately forces IDLE, pointers/lane/operand register 0, all outputs per REQ-023, busy_o=0, done_o=0, including mid-run; no partial write completes.

Configuration
REQ-025 CALC_ABORT_EN defined: input abort_i (1 bit) exists; abort_i=1 in any non-IDLE state forces IDLE next cycle, no done_o, mem_wr_en_o suppressed in that cycle.
REQ-026 CALC_ABORT_EN undefined: abort_i port absent; runs always finish.

Structure
REQ-027 calculator_pkg holds ADDR_W, DATA_W, MEM_WORD_SIZE and the FSM state enum typedef.
REQ-028 No sub-module; single FSM plus pointer registers.

Verification
REQ-029 range 0..1, write 8, mem[0]={1,2}, mem[1]={3,4} -> ops (1,2) loc_sel 0, (3,4) loc_sel 1; mem_wr_en_o at addr 8, 7 cycles after start; done_o next cycle.
REQ-030 range 4..6, write 0x10 -> reads 4,5,6; writes at 0x10 and 0x11; one buffer_write_o low cycle before second write.
REQ-031 range 5..2 -> no rd/wr enables; done_o 1 cycle after start; busy_o high 1 cycle.
REQ-032 rst_i low during WAIT -> outputs reset same cycle; fresh start 0..1 then matches REQ-029.
REQ-033 start_i held high through run -> exactly one run; with CALC_ABORT_EN, abort_i in ADD -> IDLE, no write, no done_o.
